// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared rggen bus access/status types and a width helper
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;
    function automatic int rggen_clog2(int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: rggen register bus (request from master, response from slave)
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [STROBE_WIDTH-1:0]  strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;
    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );
    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_rr_arbiter_core.sv
// rggen_rr_arbiter_core: round-robin selection with a registered grant and rotating pointer
module rggen_rr_arbiter_core
    import rggen_rtl_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = rggen_clog2(N)
)(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_request,
    input  logic          i_update,
    input  logic          i_enable,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_index
);
    logic [PW-1:0] rr_pointer;
    logic [PW-1:0] select_index;
    logic          found;
    int            j;
    // Scan from the pointer upward; the wrap is an explicit compare so odd N works.
    always_comb begin
        found        = 1'b0;
        select_index = rr_pointer;
        j            = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_pointer) + k;
            j = (j >= N) ? j - N : j;
            if (!found && i_request[j]) begin
                found        = 1'b1;
                select_index = PW'(j);
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_pointer    <= '0;
            o_grant       <= '0;
            o_grant_index <= '0;
        end else if (i_update) begin
            o_grant    <= '0;
            rr_pointer <= (o_grant_index == PW'(N - 1)) ? '0 : o_grant_index + PW'(1);
        end else if (i_enable && found) begin
            o_grant       <= N'(1) << select_index;
            o_grant_index <= select_index;
        end
    end
endmodule

// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter: round-robin sharing of one rggen bus target among N requesters
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int N_REQUESTERS  = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    rggen_bus_if.slave              bus_if_in [N_REQUESTERS],
    rggen_bus_if.master             bus_if_out,
    output logic [N_REQUESTERS-1:0] o_grant
);
    localparam int PW = rggen_clog2(N_REQUESTERS);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e                   state;
    state_e                   state_next;
    logic                     update;
    logic [N_REQUESTERS-1:0]  request;
    logic [N_REQUESTERS-1:0]  grant;
    logic [PW-1:0]            grant_index;
    rggen_access              access     [N_REQUESTERS];
    logic [ADDRESS_WIDTH-1:0] address    [N_REQUESTERS];
    logic [BUS_WIDTH-1:0]     write_data [N_REQUESTERS];
    logic [STROBE_WIDTH-1:0]  strobe     [N_REQUESTERS];
    for (genvar i = 0; i < N_REQUESTERS; i++) begin : g_port
        assign request[i]           = bus_if_in[i].valid;
        assign access[i]            = bus_if_in[i].access;
        assign address[i]           = bus_if_in[i].address;
        assign write_data[i]        = bus_if_in[i].write_data;
        assign strobe[i]            = bus_if_in[i].strobe;
        assign bus_if_in[i].ready     = (state == BUSY) && grant[i] && request[i] && bus_if_out.ready;
        assign bus_if_in[i].status    = grant[i] ? bus_if_out.status : RGGEN_OKAY;
        assign bus_if_in[i].read_data = grant[i] ? bus_if_out.read_data : '0;
    end
    rggen_rr_arbiter_core #(
        .N (N_REQUESTERS)
    ) u_core (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_request     (request),
        .i_update      (update),
        .i_enable      (state == IDLE),
        .o_grant       (grant),
        .o_grant_index (grant_index)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end
    // A granted requester dropping valid is treated as an abort, same exit as completion.
    always_comb begin
        update     = (state == BUSY) && (!request[grant_index] || bus_if_out.ready);
        state_next = (state == IDLE) ? ((|request) ? BUSY : IDLE) : (update ? IDLE : BUSY);
    end
    always_comb begin
        bus_if_out.valid      = (state == BUSY) && request[grant_index];
        bus_if_out.access     = access[grant_index];
        bus_if_out.address    = address[grant_index];
        bus_if_out.write_data = write_data[grant_index];
        bus_if_out.strobe     = strobe[grant_index];
        o_grant               = grant;
    end
endmodule
